// File: rtl/pwm_duty_sequencer_if.sv
// Target-duty request handshake between a requester and the PWM duty sequencer.
interface pwm_duty_sequencer_if #(
  parameter int unsigned DUTY_W = 4
);
  logic              req_valid;
  logic [DUTY_W-1:0] req_duty;
  logic              req_ready;

  modport master (
    output req_valid,
    output req_duty,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_duty,
    output req_ready
  );
endinterface

// File: rtl/pwm_duty_sequencer.sv
// Soft-start/soft-stop duty ramp for the PWM generator: moves duty one LSB every
// STEP_TICKS clocks toward the accepted target; estop forces duty to 0.
module pwm_duty_sequencer #(
  parameter int unsigned DUTY_W     = 4,
  parameter int unsigned STEP_TICKS = 2500000
) (
  input  logic               clk,
  input  logic               reset,
  pwm_duty_sequencer_if.slave req,
  input  logic               estop,
  output logic [DUTY_W-1:0]  duty,
  output logic               busy,
  output logic               done,
  output logic               fault
);

  localparam int unsigned CntW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STEP_TICKS - 1);

  typedef enum logic [1:0] {StIdle, StRampUp, StRampDown, StFault} state_e;

  state_e            state_q;
  logic [DUTY_W-1:0] target_q;
  logic [CntW-1:0]   cnt_q;
  logic [DUTY_W-1:0] step_duty;

  assign req.req_ready = (state_q == StIdle) && !estop;

  // Target is strictly beyond duty while ramping, so a single step can never wrap.
  always_comb begin
    step_duty = duty;
    if (state_q == StRampUp) begin
      step_duty = duty + 1'b1;
    end else if (state_q == StRampDown) begin
      step_duty = duty - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      target_q <= '0;
      cnt_q    <= '0;
      duty     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (estop) begin
        state_q  <= StFault;
        target_q <= '0;
        cnt_q    <= '0;
        duty     <= '0;
        busy     <= 1'b0;
        fault    <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (req.req_valid && req.req_ready) begin
              target_q <= req.req_duty;
              cnt_q    <= '0;
              if (req.req_duty > duty) begin
                state_q <= StRampUp;
                busy    <= 1'b1;
              end else if (req.req_duty < duty) begin
                state_q <= StRampDown;
                busy    <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end
          StRampUp, StRampDown: begin
            if (cnt_q == CntMax) begin
              cnt_q <= '0;
              duty  <= step_duty;
              if (step_duty == target_q) begin
                state_q <= StIdle;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StFault: begin
            state_q <= StIdle;
            fault   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer with STEP_TICKS=4: a per-cycle vector table
// plus hand-written ramp, estop and asynchronous-reset sequences.
module tb_pwm_duty_sequencer;

  localparam int Step = 4;

  logic       clk;
  logic       reset;
  logic       estop;
  logic [3:0] duty;
  logic       busy;
  logic       done;
  logic       fault;

  int total;
  int bad;
  int m_duty;

  pwm_duty_sequencer_if #(.DUTY_W(4)) bus ();

  pwm_duty_sequencer #(
    .DUTY_W    (4),
    .STEP_TICKS(Step)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .req  (bus),
    .estop(estop),
    .duty (duty),
    .busy (busy),
    .done (done),
    .fault(fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       valid;
    logic [3:0] rd;
    logic       es;
    logic [3:0] e_duty;
    logic       e_ready;
    logic       e_busy;
    logic       e_done;
    logic       e_fault;
  } vec_t;

  vec_t vecs[18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input int e_duty, input logic e_ready,
                         input logic e_busy, input logic e_done, input logic e_fault);
    chk({nm, ".duty"}, {4'b0, duty}, 8'(e_duty));
    chk({nm, ".ready"}, {7'b0, bus.req_ready}, {7'b0, e_ready});
    chk({nm, ".busy"}, {7'b0, busy}, {7'b0, e_busy});
    chk({nm, ".done"}, {7'b0, done}, {7'b0, e_done});
    chk({nm, ".fault"}, {7'b0, fault}, {7'b0, e_fault});
  endtask

  // Ramp from the modelled duty to tgt; optional ignored request with duty 15 before edge ign.
  task automatic ramp(input int tgt, input int ign, input string nm);
    int n;
    int exp;
    logic up;
    up = (tgt > m_duty);
    n  = up ? tgt - m_duty : m_duty - tgt;
    bus.req_valid = 1'b1;
    bus.req_duty  = 4'(tgt);
    tick();
    bus.req_valid = 1'b0;
    chk_all({nm, ".xfer"}, m_duty, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= n * Step; k++) begin
      if (k == ign) begin
        bus.req_valid = 1'b1;
        bus.req_duty  = 4'd15;
      end else begin
        bus.req_valid = 1'b0;
      end
      tick();
      exp = up ? m_duty + k / Step : m_duty - k / Step;
      chk_all($sformatf("%s.k%0d", nm, k), exp, k == n * Step, k < n * Step,
              k == n * Step, 1'b0);
    end
    bus.req_valid = 1'b0;
    m_duty = tgt;
    tick();
    chk_all({nm, ".after"}, m_duty, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_duty = 0;
    reset = 1'b0;
    estop = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_duty  = '0;

    // valid rd es | duty ready busy done fault
    vecs[0]  = '{1'b1, 4'd2,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'd0,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'd0,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'd0,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'd0,  1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'd0,  1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'd0,  1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'd0,  1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'd0,  1'b0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 4'd2,  1'b0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'd0,  1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 4'd1,  1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 4'd15, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 4'd0,  1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 4'd0,  1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 4'd0,  1'b0, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 4'd0,  1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 4'd0,  1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset held for 3 cycles, then released.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("rst%0d", i), 0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b1;
    tick();
    chk_all("rst_rel", 0, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 18; i++) begin
      bus.req_valid = vecs[i].valid;
      bus.req_duty  = vecs[i].rd;
      estop         = vecs[i].es;
      tick();
      chk_all($sformatf("vec%0d", i), int'(vecs[i].e_duty), vecs[i].e_ready,
              vecs[i].e_busy, vecs[i].e_done, vecs[i].e_fault);
    end
    bus.req_valid = 1'b0;
    estop = 1'b0;
    m_duty = 0;

    ramp(8, -1, "up8");
    ramp(1, 10, "dn1");
    ramp(5, -1, "up5");

    // Same target: done next cycle, never busy.
    bus.req_valid = 1'b1;
    bus.req_duty  = 4'd5;
    tick();
    bus.req_valid = 1'b0;
    chk_all("same", 5, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("same_after", 5, 1'b1, 1'b0, 1'b0, 1'b0);

    ramp(0, -1, "dn0");
    ramp(15, -1, "full_up");
    ramp(0, -1, "full_dn");

    // Estop mid-ramp at duty 6.
    bus.req_valid = 1'b1;
    bus.req_duty  = 4'd10;
    tick();
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 24; k++) tick();
    chk_all("pre_estop", 6, 1'b0, 1'b1, 1'b0, 1'b0);
    estop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all($sformatf("estop%0d", i), 0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    estop = 1'b0;
    tick();
    chk_all("estop_rel", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_all($sformatf("post_estop%0d", i), 0, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset between edges while ramping at duty 3.
    bus.req_valid = 1'b1;
    bus.req_duty  = 4'd4;
    tick();
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 12; k++) tick();
    chk("arst_pre.duty", {4'b0, duty}, 8'd3);
    chk("arst_pre.busy", {7'b0, busy}, 8'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst.duty", {4'b0, duty}, 8'd0);
    chk("arst.busy", {7'b0, busy}, 8'd0);
    chk("arst.done", {7'b0, done}, 8'd0);
    chk("arst.fault", {7'b0, fault}, 8'd0);
    tick();
    reset = 1'b1;
    tick();
    chk_all("arst_rel", 0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
